// File: rtl/fp_divide_seq_if.sv
// fp_divide_seq_if: operand/result handshake bundle for the sequential fixed-point divider.
interface fp_divide_seq_if #(
  parameter int AW = 9,
  parameter int BW = 9,
  parameter int QW = 18
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] A;
  logic [BW-1:0] B;
  logic          out_valid;
  logic [QW-1:0] quotient;
  logic          overflow;
  logic          div_by_zero;
  modport master (output in_valid, A, B, input in_ready, out_valid, quotient, overflow, div_by_zero);
  modport slave  (input in_valid, A, B, output in_ready, out_valid, quotient, overflow, div_by_zero);
endinterface

// File: rtl/fp_divide_seq.sv
// fp_divide_seq: signed fixed-point A/B, restoring shift-subtract core, one quotient bit per clock.
module fp_divide_seq #(
  parameter int WI1 = 4,
  parameter int WF1 = 5,
  parameter int WI2 = 4,
  parameter int WF2 = 5,
  parameter int WIO = 8,
  parameter int WFO = 10
) (
  input logic clk,
  input logic rst_n,
  fp_divide_seq_if.slave bus
);
  localparam int AW = WI1 + WF1;
  localparam int BW = WI2 + WF2;
  localparam int QW = WIO + WFO;
  localparam int NW = WI1 + WF1 + WFO + WF2;
  localparam int CW = $clog2(NW + 1);
  localparam logic [CW-1:0] LAST = CW'(NW - 1);
  localparam logic [NW-1:0] LIM = NW'(1) << (QW - 1);
  localparam logic [NW-1:0] MAXM = LIM - 1'b1;
  localparam logic [QW-1:0] MAXQ = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] MINQ = {1'b1, {(QW-1){1'b0}}};
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [NW-1:0] n_q, n_d, d_q, d_d, rem_q, rem_d, qm_q, qm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d, zero_q, zero_d;
  logic          out_valid_q, out_valid_d, ovf_q, ovf_d, dz_q, dz_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [AW-1:0] abs_a;
  logic [BW-1:0] abs_b;
  logic [NW:0]   rem_sh;
  logic          sub;
  always_comb begin
    abs_a = bus.A[AW-1] ? -bus.A : bus.A;
    abs_b = bus.B[BW-1] ? -bus.B : bus.B;
    rem_sh = {rem_q, n_q[NW-1]};
    sub = rem_sh >= {1'b0, d_q};
    state_d = state_q;
    n_d = n_q;
    d_d = d_q;
    rem_d = rem_q;
    qm_d = qm_q;
    cnt_d = cnt_q;
    sign_d = sign_q;
    zero_d = zero_q;
    out_valid_d = 1'b0;
    ovf_d = ovf_q;
    dz_d = dz_q;
    quo_d = quo_q;
    if (state_q == IDLE && bus.in_valid) begin
      // A zero dividend is forced positive so 0/-x never yields a negative zero path
      sign_d = (bus.A[AW-1] ^ bus.B[BW-1]) && (bus.A != '0);
      n_d = NW'(abs_a) << (WFO + WF2);
      d_d = NW'(abs_b) << WF1;
      rem_d = '0;
      qm_d = '0;
      cnt_d = '0;
      zero_d = bus.B == '0;
      state_d = (bus.B == '0) ? FIX : CALC;
    end else if (state_q == CALC) begin
      rem_d = NW'(sub ? rem_sh - {1'b0, d_q} : rem_sh);
      qm_d = {qm_q[NW-2:0], sub};
      n_d = n_q << 1;
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? FIX : CALC;
    end else if (state_q == FIX) begin
      // Negative results may reach exactly 2^(QW-1) in magnitude without saturating
      ovf_d = zero_q || (sign_q ? qm_q > LIM : qm_q > MAXM);
      quo_d = ovf_d ? (sign_q ? MINQ : MAXQ) : (sign_q ? QW'(-qm_q) : qm_q[QW-1:0]);
      dz_d = zero_q;
      out_valid_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q <= '0;
      d_q <= '0;
      rem_q <= '0;
      qm_q <= '0;
      cnt_q <= '0;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q <= 1'b0;
      dz_q <= 1'b0;
      quo_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      d_q <= d_d;
      rem_q <= rem_d;
      qm_q <= qm_d;
      cnt_q <= cnt_d;
      sign_q <= sign_d;
      zero_q <= zero_d;
      out_valid_q <= out_valid_d;
      ovf_q <= ovf_d;
      dz_q <= dz_d;
      quo_q <= quo_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient = quo_q;
  assign bus.overflow = ovf_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_fp_divide_seq.sv
// tb_fp_divide_seq: directed vectors with hand-computed quotients, latencies and flags.
module tb_fp_divide_seq;
  localparam int LAT = 25;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  fp_divide_seq_if #(.AW(9), .BW(9), .QW(18)) bus ();
  fp_divide_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic wait_result(output int lat, output int q, output logic ov, output logic dz);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    q = $signed(bus.quotient);
    ov = bus.overflow;
    dz = bus.div_by_zero;
  endtask

  task automatic run_div(input int a, input int b, output int lat, output int q, output logic ov, output logic dz);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 9'(a);
    bus.B = 9'(b);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_result(lat, q, ov, dz);
  endtask

  task automatic test_reset;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 18'd0 || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b ov=%b q=%0d ovf=%b dz=%b required 1 0 0 0 0", bus.in_ready, bus.out_valid, bus.quotient, bus.overflow, bus.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors(input string name, input int va[], input int vb[], input int vq[], input logic vo[], input logic vz[], input int vl[]);
    int lat, q;
    logic ov, dz;
    for (int i = 0; i < va.size(); i++) begin
      run_div(va[i], vb[i], lat, q, ov, dz);
      n_chk++;
      if (lat !== vl[i] || q !== vq[i] || ov !== vo[i] || dz !== vz[i]) begin
        n_fail++;
        $display("FAIL %s[%0d] %0d/%0d: lat=%0d q=%0d ovf=%b dz=%b required lat=%0d q=%0d ovf=%b dz=%b",
                 name, i, va[i], vb[i], lat, q, ov, dz, vl[i], vq[i], vo[i], vz[i]);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s[%0d] strobe width: out_valid=%b required 0", name, i, bus.out_valid);
      end
    end
  endtask

  task automatic test_basic;
    test_vectors("basic", '{96, -96, 32, -32, 0}, '{48, 16, 96, 96, -80}, '{2048, -6144, 341, -341, 0},
                 '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, '{LAT, LAT, LAT, LAT, LAT});
  endtask

  task automatic test_saturation;
    test_vectors("sat", '{255, -128, -256, -255}, '{1, 1, -256, 1}, '{131071, -131072, 1024, -131072},
                 '{1'b1, 1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0, 1'b0}, '{LAT, LAT, LAT, LAT});
  endtask

  task automatic test_div_zero;
    test_vectors("divzero", '{32, -32, 0}, '{0, 0, 0}, '{131071, -131072, 131071},
                 '{1'b1, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b1}, '{1, 1, 1});
  endtask

  task automatic test_ignore;
    int lat = -1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 9'sd96;
    bus.B = 9'sd48;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin
        bus.in_valid = 1'b1;
        bus.A = 9'sd255;
        bus.B = 9'sd1;
        n_chk++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore in_ready: %b required 0", bus.in_ready);
        end
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    n_chk++;
    if (lat !== LAT || $signed(bus.quotient) !== 2048 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore result: lat=%0d q=%0d ovf=%b required lat=%0d q=2048 ovf=0", lat, $signed(bus.quotient), bus.overflow, LAT);
    end
  endtask

  task automatic test_back_to_back;
    int lat, q;
    logic ov, dz;
    run_div(32, 96, lat, q, ov, dz);
    n_chk++;
    if (lat !== LAT || q !== 341) begin
      n_fail++;
      $display("FAIL b2b first: lat=%0d q=%0d required lat=%0d q=341", lat, q, LAT);
    end
    bus.in_valid = 1'b1;
    bus.A = -9'sd96;
    bus.B = 9'sd16;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_result(lat, q, ov, dz);
    n_chk++;
    if (lat !== LAT || q !== -6144 || ov !== 1'b0 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b second: lat=%0d q=%0d ovf=%b dz=%b required lat=%0d q=-6144 ovf=0 dz=0", lat, q, ov, dz, LAT);
    end
  endtask

  task automatic test_reset_mid;
    int lat, q;
    logic ov, dz;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 9'sd255;
    bus.B = 9'sd1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 18'd0 || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: rdy=%b ov=%b q=%0d ovf=%b dz=%b required 1 0 0 0 0", bus.in_ready, bus.out_valid, bus.quotient, bus.overflow, bus.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_div(96, 48, lat, q, ov, dz);
    n_chk++;
    if (lat !== LAT || q !== 2048 || ov !== 1'b0 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL after reset: lat=%0d q=%0d ovf=%b dz=%b required lat=%0d q=2048 ovf=0 dz=0", lat, q, ov, dz, LAT);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_div_zero();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
